// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, widths and the BTB entry update rule
package btb_pkg;

  localparam int PC_W    = 14;
  localparam int IDX_W   = 9;
  localparam int TAG_W   = 5;
  localparam int FIFO_D  = 4;
  localparam int ENTRY_W = TAG_W + 2 + PC_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             v;
    logic             s;
    logic [PC_W-1:0]  tgt;
  } btb_entry_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } upd_rec_t;

  typedef struct packed {
    logic       we;
    btb_entry_t entry;
  } btb_wr_t;

  typedef enum logic [1:0] {CLEAR, IDLE, RD, WB} state_e;

  // Two-level confidence: S marks a strong entry; a not-taken hit first weakens, then invalidates.
  function automatic btb_wr_t btb_update(input btb_entry_t cur, input upd_rec_t rec);
    btb_wr_t r;
    logic    hit;
    hit         = cur.v && (cur.tag == rec.pc[PC_W-1:IDX_W]);
    r.we        = 1'b0;
    r.entry     = cur;
    r.entry.tag = rec.pc[PC_W-1:IDX_W];
    if (rec.taken) begin
      if (!hit) begin
        r.we        = 1'b1;
        r.entry.v   = 1'b1;
        r.entry.s   = 1'b0;
        r.entry.tgt = rec.target;
      end else if (cur.tgt == rec.target) begin
        r.we        = !cur.s;
        r.entry.s   = 1'b1;
      end else begin
        r.we        = 1'b1;
        r.entry.s   = 1'b0;
        r.entry.tgt = rec.target;
      end
    end else if (hit) begin
      r.we = 1'b1;
      if (cur.s) r.entry.s = 1'b0;
      else       r.entry.v = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - synchronous FIFO of resolved-branch records
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = FIFO_D
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  upd_rec_t din_i,
  input  logic     pop_i,
  output upd_rec_t head_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     last_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        do_push, do_pop;
  upd_rec_t    mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign last_o  = (count == {{AW{1'b0}}, 1'b1});
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/btb_update_engine.sv
// rtl/btb_update_engine.sv - BTB write side: clear sweep, then buffered read-modify-write updates
module btb_update_engine
  import btb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic [PC_W-1:0]    upd_target,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_addr,
  output logic [ENTRY_W-1:0] wr_data,
  output logic               init_done,
  output logic               busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;

  upd_rec_t   push_rec, head;
  logic       push, pop, fifo_full, fifo_empty, fifo_last;
  btb_entry_t rd_entry;
  btb_wr_t    upd_res;

  assign push_rec  = '{pc: upd_pc, taken: upd_taken, target: upd_target};
  // Ready depends only on registered state; a pop in the same cycle never frees a slot early.
  assign upd_ready = init_done_q && !fifo_full;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state_q == WB);

  btb_upd_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_rec),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  assign rd_entry  = btb_entry_t'(rd_data);
  assign upd_res   = btb_update(rd_entry, head);
  assign init_done = init_done_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    unique case (state_q)
      CLEAR: begin
        // Gated by rst_n so the sweep write is withdrawn the moment reset asserts.
        wr_en   = rst_n;
        wr_addr = rst_n ? cnt_q : '0;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == {IDX_W{1'b1}}) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (!fifo_empty) state_d = RD;
      end
      RD: begin
        rd_en   = 1'b1;
        rd_addr = head.pc[IDX_W-1:0];
        state_d = WB;
      end
      WB: begin
        wr_en   = upd_res.we;
        wr_addr = upd_res.we ? head.pc[IDX_W-1:0] : '0;
        wr_data = upd_res.we ? upd_res.entry : '0;
        state_d = fifo_last ? IDLE : RD;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: tb/tb_btb_update_engine.sv
// tb/tb_btb_update_engine.sv - directed self-checking bench for btb_update_engine
module tb_btb_update_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid, upd_ready, upd_taken;
  logic [13:0] upd_pc, upd_target;
  logic        rd_en, wr_en, init_done, busy;
  logic [8:0]  rd_addr, wr_addr;
  logic [20:0] rd_data = '0;
  logic [20:0] wr_data;

  logic [20:0] store [512];
  logic [8:0]  wa_q [$];
  logic [20:0] wd_q [$];
  int          wc_q [$];
  int          ncyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  btb_update_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .init_done  (init_done),
    .busy       (busy)
  );

  // Synchronous store with one-cycle read latency, no write-to-read forwarding.
  always @(posedge clk) begin
    if (wr_en) store[wr_addr] <= wr_data;
    if (rd_en) rd_data <= store[rd_addr];
  end

  always @(negedge clk) begin
    ncyc++;
    if (wr_en && init_done) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(ncyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic check_sweep(input string tag);
    int errs = 0;
    for (int i = 0; i < 512; i++) begin
      if (!(wr_en === 1'b1 && wr_addr === 9'(i) && wr_data === 21'h0 && rd_en === 1'b0
            && init_done === 1'b0 && upd_ready === 1'b0)) errs++;
      @(negedge clk);
    end
    check({tag, "_errs"}, errs, 0);
    check({tag, "_init_done"}, init_done, 1);
    check({tag, "_ready"}, upd_ready, 1);
    check({tag, "_wr_en_off"}, wr_en, 0);
  endtask

  task automatic push_one(input logic [13:0] pc, input logic tk, input logic [13:0] tg, input string tag);
    int guard = 0;
    upd_pc = pc; upd_taken = tk; upd_target = tg; upd_valid = 1'b1;
    while (!upd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int guard = 0;
    while (busy && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_update(input logic [13:0] pc, input logic tk, input logic [13:0] tg,
                           input string tag, input int exp_n, input logic [8:0] exp_a,
                           input logic [20:0] exp_d);
    clear_log();
    push_one(pc, tk, tg, tag);
    wait_idle(tag, 20);
    check({tag, "_nwr"}, wa_q.size(), exp_n);
    if (exp_n == 1 && wa_q.size() == 1) begin
      check({tag, "_addr"}, wa_q[0], exp_a);
      check({tag, "_data"}, wd_q[0], exp_d);
    end
  endtask

  logic [13:0] b_pc   [6] = '{14'h0100, 14'h0101, 14'h0102, 14'h0103, 14'h0104, 14'h0104};
  logic [13:0] b_tgt  [6] = '{14'h0200, 14'h0201, 14'h0202, 14'h0203, 14'h0204, 14'h0204};
  logic [20:0] b_data [6] = '{21'h08200, 21'h08201, 21'h08202, 21'h08203, 21'h08204, 21'h0C204};

  initial begin
    int k, guard, errs;
    logic acc, stall_seen;
    rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", upd_ready, 0);
    check("rst_busy", busy, 1);
    #2 rst_n = 1'b1;
    #1 check_sweep("sweep");
    check("post_sweep_busy", busy, 0);

    // First allocate, checked cycle by cycle for latency and zeroed idle outputs.
    clear_log();
    upd_pc = 14'h0A05; upd_taken = 1'b1; upd_target = 14'h0123; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    check("lat_c1_busy", busy, 1);
    check("lat_c1_wr", wr_en, 0);
    @(negedge clk);
    check("lat_c2_rd_en", rd_en, 1);
    check("lat_c2_rd_addr", rd_addr, 9'h005);
    check("lat_c2_wr_addr0", wr_addr, 0);
    @(negedge clk);
    check("lat_c3_wr_en", wr_en, 1);
    check("lat_c3_wr_addr", wr_addr, 9'h005);
    check("lat_c3_wr_data", wr_data, 21'h58123);
    check("lat_c3_rd_en", rd_en, 0);
    check("lat_c3_rd_addr0", rd_addr, 0);
    @(negedge clk);
    check("lat_c4_wr_en", wr_en, 0);
    check("lat_c4_busy", busy, 0);

    do_update(14'h0A05, 1'b1, 14'h0123, "strengthen", 1, 9'h005, 21'h5C123);
    do_update(14'h0A05, 1'b1, 14'h0123, "strong_hold", 0, 9'h000, 21'h0);
    do_update(14'h0A05, 1'b0, 14'h0000, "weaken", 1, 9'h005, 21'h58123);
    do_update(14'h0A05, 1'b0, 14'h0000, "invalidate", 1, 9'h005, 21'h50123);
    do_update(14'h0A05, 1'b0, 14'h0000, "nt_miss", 0, 9'h000, 21'h0);
    do_update(14'h0A05, 1'b1, 14'h0456, "realloc", 1, 9'h005, 21'h58456);
    do_update(14'h0C05, 1'b1, 14'h0777, "replace", 1, 9'h005, 21'h68777);
    do_update(14'h0C05, 1'b1, 14'h0111, "retarget", 1, 9'h005, 21'h68111);
    do_update(14'h0A05, 1'b0, 14'h0000, "nt_tag_miss", 0, 9'h000, 21'h0);

    // Back-to-back burst overruns the 4-deep FIFO; last two records share an index.
    clear_log();
    k = 0; guard = 0; stall_seen = 1'b0;
    while (k < 6 && guard < 100) begin
      upd_pc = b_pc[k]; upd_taken = 1'b1; upd_target = b_tgt[k]; upd_valid = 1'b1;
      acc = upd_ready;
      if (!acc) stall_seen = 1'b1;
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    upd_valid = 1'b0;
    check("burst_accepted", k, 6);
    check("burst_stall", stall_seen, 1);
    wait_idle("burst", 40);
    check("burst_nwr", wa_q.size(), 6);
    errs = 0;
    for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
      if (wa_q[i] !== b_pc[i][8:0] || wd_q[i] !== b_data[i]) errs++;
      if (i > 0 && (wc_q[i] - wc_q[i-1]) != 2) errs++;
    end
    check("burst_order_errs", errs, 0);

    // Reset in the middle of a WB with three records buffered.
    clear_log();
    for (int i = 0; i < 3; i++) begin
      upd_pc = 14'h0300 + 14'(i); upd_taken = 1'b1; upd_target = 14'h0011; upd_valid = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("mid_wb_wr_en", wr_en, 1);
    check("mid_wb_wr_addr", wr_addr, 9'h100);
    #2 rst_n = 1'b0;
    #1;
    check("areset_wr_en", wr_en, 0);
    check("areset_rd_en", rd_en, 0);
    check("areset_ready", upd_ready, 0);
    check("areset_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("areset_hold_wr_en", wr_en, 0);
    clear_log();
    #2 rst_n = 1'b1;
    #1 check_sweep("resweep");
    check("resweep_fifo_empty", busy, 0);
    check("resweep_store5", store[9'h005], 0);
    check("resweep_store100", store[9'h100], 0);
    repeat (6) @(negedge clk);
    check("no_replay_nwr", wa_q.size(), 0);
    check("no_replay_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
